// File: rtl/barrel_shifter_pkg.sv
// Shared widths, word type and bit-reversal helper for the 32-bit barrel shifter.
package barrel_shifter_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef logic [WIDTH-1:0] word_t;

  // Mirrors bit i to bit WIDTH-1-i; lets a right-shift datapath also produce left shifts.
  function automatic word_t bit_reverse(input word_t w);
    word_t r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r[i] = w[WIDTH-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One log-shifter stage: optional right shift by DIST with a caller-supplied fill bit.
module shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int unsigned DIST = 1
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_fill,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_word
);

  logic [WIDTH-1:0] w_shifted;

  assign w_shifted = {{DIST{i_fill}}, i_word[WIDTH-1:DIST]};
  assign o_word    = i_sel ? w_shifted : i_word;

endmodule

// File: rtl/barrel_shifter_32.sv
// 32-bit SLL/SRA barrel shifter. Output register present when BARREL_SHIFTER_OUTREG_EN is
// defined; otherwise the result is purely combinational and clock/reset_n are unused.
module barrel_shifter_32
  import barrel_shifter_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] shiftamt,
  input  logic               left,
  output logic [WIDTH-1:0]   out
);

  word_t w_pre;
  word_t w_res;
  logic  w_fill;
  word_t w_stage [SHAMT_W+1];

  // Left shifts run through the same right-shift stages on a mirrored operand.
  assign w_fill     = left ? 1'b0 : in[WIDTH-1];
  assign w_pre      = left ? bit_reverse(in) : in;
  assign w_stage[0] = w_pre;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .DIST(32'd1 << k)
    ) u_stage (
      .i_word(w_stage[k]),
      .i_fill(w_fill),
      .i_sel (shiftamt[k]),
      .o_word(w_stage[k+1])
    );
  end

  assign w_res = left ? bit_reverse(w_stage[SHAMT_W]) : w_stage[SHAMT_W];

`ifdef BARREL_SHIFTER_OUTREG_EN
  word_t r_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_res;
    end
  end

  assign out = r_out;
`else
  logic w_unused_clk_rst;

  assign w_unused_clk_rst = clock ^ reset_n;
  assign out              = w_res;
`endif

endmodule

// File: tb/tb_barrel_shifter_32.sv
// Directed and sweep bench for barrel_shifter_32; inputs change on the falling edge and the
// output is checked one full cycle later, so it suits both the registered and combinational builds.
module tb_barrel_shifter_32;

  logic        clock;
  logic        reset_n;
  logic [31:0] in;
  logic [4:0]  shiftamt;
  logic        left;
  logic [31:0] out;

  int unsigned n_checks;
  int unsigned n_bad;

  barrel_shifter_32 u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .in      (in),
    .shiftamt(shiftamt),
    .left    (left),
    .out     (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Called on a falling edge: drive, wait one full cycle, compare.
  task automatic run_vec(input string tag, input logic [31:0] a, input logic [4:0] amt,
                         input logic l, input logic [31:0] exp);
    in       = a;
    shiftamt = amt;
    left     = l;
    @(negedge clock);
    check_eq(tag, out, exp);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] exp;

    n_checks = 0;
    n_bad    = 0;
    reset_n  = 1'b1;
    in       = 32'hDEADBEEF;
    shiftamt = 5'd4;
    left     = 1'b1;

    @(negedge clock);
    @(negedge clock);
    check_eq("pre_reset", out, 32'hEADBEEF0);

    // Assert reset between edges; a registered output must clear without a clock edge.
    #2 reset_n = 1'b0;
    #1;
`ifdef BARREL_SHIFTER_OUTREG_EN
    check_eq("reset_async", out, 32'h00000000);
    @(negedge clock);
    check_eq("reset_held", out, 32'h00000000);
`else
    check_eq("reset_ignored", out, 32'hEADBEEF0);
    @(negedge clock);
`endif

    reset_n = 1'b1;
    run_vec("release_amt0", 32'h77F1F54E, 5'd0, 1'b1, 32'h77F1F54E);

    run_vec("sll_pos_20",  32'h77F1F54E, 5'd20, 1'b1, 32'h54E00000);
    run_vec("sll_pos_31",  32'h77F1F54E, 5'd31, 1'b1, 32'h00000000);
    run_vec("sll_neg_20",  32'h880E0AB2, 5'd20, 1'b1, 32'hAB200000);
    run_vec("sll_one_31",  32'h00000001, 5'd31, 1'b1, 32'h80000000);
    run_vec("sra_pos_20",  32'h77F1F54E, 5'd20, 1'b0, 32'h0000077F);
    run_vec("sra_pos_31",  32'h77F1F54E, 5'd31, 1'b0, 32'h00000000);
    run_vec("sra_pos_0",   32'h77F1F54E, 5'd0,  1'b0, 32'h77F1F54E);
    run_vec("sra_neg_20",  32'h880E0AB2, 5'd20, 1'b0, 32'hFFFFF880);
    run_vec("sra_neg_31",  32'h880E0AB2, 5'd31, 1'b0, 32'hFFFFFFFF);
    run_vec("sra_neg_0",   32'h880E0AB2, 5'd0,  1'b0, 32'h880E0AB2);
    run_vec("sra_neg_1",   32'h80000000, 5'd1,  1'b0, 32'hC0000000);
    run_vec("sll_pos_1",   32'h80000001, 5'd1,  1'b1, 32'h00000002);
    run_vec("zero_sra_20", 32'h00000000, 5'd20, 1'b0, 32'h00000000);
    run_vec("zero_sll_20", 32'h00000000, 5'd20, 1'b1, 32'h00000000);

`ifdef BARREL_SHIFTER_OUTREG_EN
    // Inputs changed after the sampling edge must not reach out until the next edge.
    in       = 32'h77F1F54E;
    shiftamt = 5'd20;
    left     = 1'b1;
    @(posedge clock);
    #2;
    in       = 32'h880E0AB2;
    left     = 1'b0;
    #1;
    check_eq("hold_after_edge", out, 32'h54E00000);
    @(negedge clock);
    check_eq("hold_mid_cycle", out, 32'h54E00000);
    @(negedge clock);
    check_eq("hold_next_edge", out, 32'hFFFFF880);
`endif

    for (int amt = 0; amt < 32; amt++) begin
      for (int l = 0; l < 2; l++) begin
        a = $urandom();
        if (l == 1) exp = a << amt;
        else        exp = $signed(a) >>> amt;
        run_vec($sformatf("sweep_a%08h_s%0d_l%0d", a, amt, l), a, 5'(amt), 1'(l), exp);
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
